output_drain_ctrl: RTL and testbench

- Downstream neighbour of the output-buffer fill stage.
- Once a layer's output feature map is in the output buffer, this block reads it back word by word, from a base address, for N×N words.
- Words are streamed to the next consumer (next-layer input loader or host DMA) over a valid/ready interface.
- Absorbs the buffer's 1-cycle read latency with a 2-entry skid FIFO, so throughput is one word per cycle under continuous ready.

---
 rtl/output_drain_ctrl.sv | 151 +++++++++++++++
 tb/tb_output_drain_ctrl.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/output_drain_ctrl.sv
// rtl/output_drain_ctrl.sv - streams an N*N output feature map out of the output buffer
//
// Purpose:
//   Reads N*N words back from the output buffer, starting at a base address.
//   Each word goes out on a valid/ready stream. A 2-entry skid FIFO hides the
//   buffer's 1-cycle read latency, so one word per cycle flows under continuous ready.
//
// Ports:
//   w_clk                  clock, rising edge
//   reset                  asynchronous active-low reset
//   start                  one-cycle launch pulse, honoured only in IDLE
//   base_address           first buffer address, latched on the accepted start
//   output_featuremapsize  side length N, latched (as N*N) on the accepted start
//   is_empty               buffer has nothing readable; stalls new reads only
//   rd_data                buffer read data, valid the cycle after read_enable
//   read_enable            buffer read strobe
//   rd_address             buffer read address (wraps modulo 2^ADDR_W)
//   m_data / m_valid       stream data (FIFO head) and valid
//   m_ready                stream ready
//   busy                   accepted start through the done cycle, inclusive
//   done                   one-cycle pulse after the final handshake
module output_drain_ctrl #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16
) (
  input  logic              w_clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_address,
  input  logic [7:0]        output_featuremapsize,
  input  logic              is_empty,
  input  logic [DATA_W-1:0] rd_data,
  output logic              read_enable,
  output logic [ADDR_W-1:0] rd_address,
  output logic [DATA_W-1:0] m_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {IDLE, DRAIN, DONE} state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] base_q;
  logic [15:0]       total;
  logic [15:0]       issued;
  logic [15:0]       delivered;
  logic              inflight;
  logic [1:0]        occ;
  logic [DATA_W-1:0] fifo_mem [2];
  logic              wr_ptr;
  logic              rd_ptr;
  logic              launch;
  logic              pop;
  logic              last_pop;

  assign launch   = (state == IDLE) && start;
  assign m_valid  = (occ != 2'd0);
  assign pop      = m_valid && m_ready;
  assign last_pop = pop && (delivered == total - 16'd1);
  assign m_data   = fifo_mem[rd_ptr];
  assign rd_address = base_q + issued[ADDR_W-1:0];

  // State register
  always_ff @(posedge w_clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = (output_featuremapsize == 8'd0) ? DONE : DRAIN;
        end
      end
      DRAIN: begin
        // Leave in the same cycle as the final handshake.
        if (last_pop) begin
          state_nxt = DONE;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    read_enable = 1'b0;
    busy        = (state != IDLE);
    done        = (state == DONE);
    // Credit rule: a read is allowed only if the word it returns has a FIFO
    // slot. Slots already claimed are occ plus the in-flight word. A pop this
    // cycle frees one, so occ + inflight - pop < 2 is required.
    if ((state == DRAIN) && (issued < total) && !is_empty &&
        (({1'b0, occ} + {2'b0, inflight}) < (3'd2 + {2'b0, pop}))) begin
      read_enable = 1'b1;
    end
  end

  // Counters, read pipeline and skid FIFO
  always_ff @(posedge w_clk or negedge reset) begin
    if (!reset) begin
      base_q      <= '0;
      total       <= '0;
      issued      <= '0;
      delivered   <= '0;
      inflight    <= 1'b0;
      occ         <= 2'd0;
      wr_ptr      <= 1'b0;
      rd_ptr      <= 1'b0;
      fifo_mem[0] <= '0;
      fifo_mem[1] <= '0;
    end else begin
      if (launch) begin
        base_q    <= base_address;
        total     <= {8'd0, output_featuremapsize} * {8'd0, output_featuremapsize};
        issued    <= '0;
        delivered <= '0;
      end else begin
        if (read_enable) issued    <= issued + 16'd1;
        if (pop)         delivered <= delivered + 16'd1;
      end

      inflight <= read_enable;

      // The word read last cycle lands now.
      if (inflight) begin
        fifo_mem[wr_ptr] <= rd_data;
        wr_ptr           <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end

      case ({inflight, pop})
        2'b10:   occ <= occ + 2'd1;
        2'b01:   occ <= occ - 2'd1;
        default: occ <= occ;
      endcase
    end
  end

endmodule

// File: tb/tb_output_drain_ctrl.sv
// tb/tb_output_drain_ctrl.sv - self-checking bench for output_drain_ctrl
module tb_output_drain_ctrl;

  logic        w_clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  base_address = 8'd0;
  logic [7:0]  output_featuremapsize = 8'd0;
  logic        is_empty = 1'b0;
  logic [15:0] rd_data = 16'd0;
  logic        read_enable;
  logic [7:0]  rd_address;
  logic [15:0] m_data;
  logic        m_valid;
  logic        m_ready = 1'b0;
  logic        busy;
  logic        done;

  output_drain_ctrl #(.ADDR_W(8), .DATA_W(16)) dut (
    .w_clk                 (w_clk),
    .reset                 (reset),
    .start                 (start),
    .base_address          (base_address),
    .output_featuremapsize (output_featuremapsize),
    .is_empty              (is_empty),
    .rd_data               (rd_data),
    .read_enable           (read_enable),
    .rd_address            (rd_address),
    .m_data                (m_data),
    .m_valid               (m_valid),
    .m_ready               (m_ready),
    .busy                  (busy),
    .done                  (done)
  );

  always #5 w_clk = ~w_clk;

  // Buffer model: 1-cycle read latency.
  logic [15:0] buf_mem [256];
  always @(posedge w_clk) begin
    if (read_enable) rd_data <= buf_mem[rd_address];
  end

  int cyc = 0;
  always @(posedge w_clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Observed activity, recorded at the falling edge.
  logic [7:0]  rd_q  [$];
  logic [15:0] got_q [$];
  int first_re, last_re, first_hs, last_hs, first_mv, done_cyc, done_cnt;
  bit          prev_stall = 1'b0;
  logic [15:0] prev_data  = 16'd0;

  task automatic clear_obs();
    rd_q.delete();
    got_q.delete();
    first_re = -1; last_re = -1; first_hs = -1; last_hs = -1;
    first_mv = -1; done_cyc = -1; done_cnt = 0;
  endtask

  always @(negedge w_clk) begin
    if (!reset) begin
      prev_stall = 1'b0;
    end else begin
      // reads issued earlier minus words delivered earlier = words held or in flight
      chk("credit_le2", 32'((rd_q.size() - got_q.size()) <= 2), 32'd1);
      if (prev_stall) begin
        chk("stall_valid", 32'(m_valid), 32'd1);
        chk("stall_data", 32'(m_data), 32'(prev_data));
      end
      if (read_enable) begin
        chk("read_while_empty", 32'(is_empty), 32'd0);
        if (first_re < 0) first_re = cyc;
        last_re = cyc;
        rd_q.push_back(rd_address);
      end
      if (m_valid && first_mv < 0) first_mv = cyc;
      if (m_valid && m_ready) begin
        if (first_hs < 0) first_hs = cyc;
        last_hs = cyc;
        got_q.push_back(m_data);
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      prev_stall = m_valid && !m_ready;
      prev_data  = m_data;
    end
  end

  // rmode: 0 ready always, 1 pattern 1,0,0,1, 2 random.
  task automatic drain(input logic [7:0] b, input logic [7:0] n, input int rmode,
                       input int e_at, input int e_len, input bit restart, input bit strict);
    int total;
    int k;
    int budget;
    int start_c;
    total  = int'(n) * int'(n);
    budget = 6 * total + 40;
    k      = 0;
    clear_obs();
    @(posedge w_clk); #1;
    base_address          = b;
    output_featuremapsize = n;
    start                 = 1'b1;
    is_empty              = 1'b0;
    m_ready               = (rmode == 0);
    start_c               = cyc;
    while (done_cnt == 0 && k < budget) begin
      @(posedge w_clk); #1;
      k++;
      start = restart && (k == 3 || k == 5);
      if (restart) begin
        base_address          = ~b;
        output_featuremapsize = n + 8'd2;
      end
      case (rmode)
        0:       m_ready = 1'b1;
        1:       m_ready = (k % 4 == 0) || (k % 4 == 3);
        default: m_ready = 1'($urandom_range(0, 1));
      endcase
      is_empty = (k >= e_at) && (k < e_at + e_len);
      if (k == 1) chk("busy_on", 32'(busy), 32'd1);
    end
    start    = 1'b0;
    is_empty = 1'b0;
    m_ready  = 1'b1;
    chk("timeout", 32'(done_cnt != 0), 32'd1);
    chk("done_count", 32'(done_cnt), 32'd1);
    chk("busy_after", 32'(busy), 32'd0);
    chk("done_after", 32'(done), 32'd0);
    chk("n_reads", 32'(rd_q.size()), 32'(total));
    chk("n_words", 32'(got_q.size()), 32'(total));
    for (int i = 0; i < total && i < got_q.size(); i++)
      chk("word", 32'(got_q[i]), 32'(buf_mem[(int'(b) + i) % 256]));
    for (int i = 0; i < total && i < rd_q.size(); i++)
      chk("addr", 32'(rd_q[i]), 32'((int'(b) + i) % 256));
    if (total > 0) begin
      chk("done_timing", 32'(done_cyc), 32'(last_hs + 1));
      chk("latency_min", 32'((first_mv - first_re) >= 2), 32'd1);
      if (strict) begin
        chk("latency_2", 32'(first_mv - first_re), 32'd2);
        chk("read_burst", 32'(last_re - first_re), 32'(total - 1));
        chk("word_burst", 32'(last_hs - first_hs), 32'(total - 1));
      end
    end else begin
      chk("done_n0", 32'(done_cyc), 32'(start_c + 1));
      chk("no_valid_n0", 32'(first_mv), 32'hFFFF_FFFF);
    end
  endtask

  initial begin
    for (int a = 0; a < 256; a++) buf_mem[a] = 16'(a);
    clear_obs();
    #2 reset = 1'b0;
    repeat (3) @(posedge w_clk);
    #1;
    chk("rst_read_enable", 32'(read_enable), 32'd0);
    chk("rst_rd_address", 32'(rd_address), 32'd0);
    chk("rst_m_valid", 32'(m_valid), 32'd0);
    chk("rst_m_data", 32'(m_data), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    @(posedge w_clk); #1;
    reset = 1'b1;

    // Continuous flow
    drain(8'h10, 8'd3, 0, -1, 0, 1'b0, 1'b1);
    // Backpressure 1,0,0,1
    drain(8'h10, 8'd3, 1, -1, 0, 1'b0, 1'b0);
    // Address wrap
    drain(8'hFE, 8'd2, 0, -1, 0, 1'b0, 1'b1);
    // Buffer empty stall mid-drain
    drain(8'h30, 8'd4, 0, 4, 5, 1'b0, 1'b0);
    // N=0, then start ignored while busy
    drain(8'h55, 8'd0, 0, -1, 0, 1'b0, 1'b0);
    drain(8'h10, 8'd3, 0, -1, 0, 1'b1, 1'b1);

    // Reset mid-drain after 4 words
    clear_obs();
    @(posedge w_clk); #1;
    base_address          = 8'h20;
    output_featuremapsize = 8'd3;
    start                 = 1'b1;
    m_ready               = 1'b1;
    for (int k = 0; k < 40 && got_q.size() < 4; k++) begin
      @(posedge w_clk); #1;
      start = 1'b0;
    end
    chk("mid_words_seen", 32'(got_q.size() >= 4), 32'd1);
    reset = 1'b0;
    #1;
    chk("mid_rst_read_enable", 32'(read_enable), 32'd0);
    chk("mid_rst_rd_address", 32'(rd_address), 32'd0);
    chk("mid_rst_m_valid", 32'(m_valid), 32'd0);
    chk("mid_rst_m_data", 32'(m_data), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_done", 32'(done), 32'd0);
    repeat (2) @(posedge w_clk);
    #1;
    reset = 1'b1;
    clear_obs();
    drain(8'h40, 8'd2, 0, -1, 0, 1'b0, 1'b1);

    // Randomised drains over random buffer contents
    for (int a = 0; a < 256; a++) buf_mem[a] = 16'($urandom);
    for (int t = 0; t < 8; t++) begin
      drain(8'($urandom), 8'($urandom_range(1, 12)), 2,
            int'($urandom_range(1, 20)), int'($urandom_range(0, 6)), 1'b0, 1'b0);
    end
    drain(8'($urandom), 8'd6, 0, -1, 0, 1'b0, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Hard stop in case a bounded wait is broken.
  initial begin
    #2000000;
    $display("FAIL global_timeout: observed running expected finished");
    $fatal(1, "global timeout");
  end

endmodule
